// File: rtl/exe_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exe_issue_pipe
// Purpose  : Execute-stage holding register with valid/ready handshake,
//            prioritised operand forwarding, load-use stall, multicycle hold
//            and wrong-path squash on taken branches.
// Revision : 1.0
// ============================================================================
module exe_issue_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_FWD   = 2,
    parameter int PAYLOAD_W = 237,
    parameter int CNT_W     = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [PAYLOAD_W-1:0]              in_payload,
    input  logic [REG_AW-1:0]                 in_rj,
    input  logic [REG_AW-1:0]                 in_rkd,
    input  logic [DATA_W-1:0]                 in_rj_value,
    input  logic [DATA_W-1:0]                 in_rkd_value,
    input  logic [CNT_W-1:0]                  in_mc_cycles,
    input  logic [NUM_FWD*(2+REG_AW+DATA_W)-1:0] fwd_bus,
    input  logic                              br_taken,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PAYLOAD_W-1:0]              out_payload,
    output logic [DATA_W-1:0]                 src1,
    output logic [DATA_W-1:0]                 src2,
    output logic                              busy
);

    localparam int c_SRC_W = 2 + REG_AW + DATA_W;

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [REG_AW-1:0]    r_rj;
    logic [REG_AW-1:0]    r_rkd;
    logic [DATA_W-1:0]    r_v1;
    logic [DATA_W-1:0]    r_v2;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_fwd_we   [NUM_FWD];
    logic                 w_fwd_pend [NUM_FWD];
    logic [REG_AW-1:0]    w_fwd_dest [NUM_FWD];
    logic [DATA_W-1:0]    w_fwd_data [NUM_FWD];

    logic w_pend1, w_pend2, w_hazard, w_complete, w_fire, w_accept;

    generate
        for (genvar g = 0; g < NUM_FWD; g++) begin : g_unpack
            assign w_fwd_we[g]   = fwd_bus[g*c_SRC_W + DATA_W + REG_AW + 1];
            assign w_fwd_pend[g] = fwd_bus[g*c_SRC_W + DATA_W + REG_AW];
            assign w_fwd_dest[g] = fwd_bus[g*c_SRC_W + DATA_W +: REG_AW];
            assign w_fwd_data[g] = fwd_bus[g*c_SRC_W +: DATA_W];
        end
    endgenerate

    // Scan oldest to youngest so the lowest-index match is the last write.
    // A pending winner leaves the held value on the bus; it is never consumed.
    always_comb begin
        src1    = r_v1;
        src2    = r_v2;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_fwd_we[i] && (r_rj != '0) && (w_fwd_dest[i] == r_rj)) begin
                w_pend1 = w_fwd_pend[i];
                src1    = w_fwd_pend[i] ? r_v1 : w_fwd_data[i];
            end
            if (w_fwd_we[i] && (r_rkd != '0) && (w_fwd_dest[i] == r_rkd)) begin
                w_pend2 = w_fwd_pend[i];
                src2    = w_fwd_pend[i] ? r_v2 : w_fwd_data[i];
            end
        end
    end

    assign w_hazard    = r_valid & (w_pend1 | w_pend2);
    assign w_complete  = r_valid & ~w_hazard & (r_cnt == '0);
    assign out_valid   = w_complete & ~flush & ~reset;
    assign w_fire      = out_valid & out_ready;
    assign in_ready    = ~reset & ~flush & (~r_valid | w_fire);
    assign w_accept    = in_valid & in_ready;
    assign busy        = r_valid & ~w_complete;
    assign out_payload = r_payload;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_rj      <= '0;
            r_rkd     <= '0;
            r_v1      <= '0;
            r_v2      <= '0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // A beat taken while a taken branch leaves is wrong-path: drop it.
            r_valid   <= ~(w_fire & br_taken);
            r_payload <= in_payload;
            r_rj      <= in_rj;
            r_rkd     <= in_rkd;
            r_v1      <= in_rj_value;
            r_v2      <= in_rkd_value;
            r_cnt     <= in_mc_cycles;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Capture draining-stage results so a stall does not lose them.
            r_v1 <= src1;
            r_v2 <= src2;
            if (!w_hazard && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_issue_pipe.sv
`default_nettype none
// Directed testbench for exe_issue_pipe: forwarding priority, load-use stall,
// multicycle hold, backpressure, branch squash, flush and reset.
module tb_exe_issue_pipe;

    localparam int DATA_W    = 32;
    localparam int REG_AW    = 5;
    localparam int NUM_FWD   = 2;
    localparam int PAYLOAD_W = 237;
    localparam int CNT_W     = 6;
    localparam int SW        = 2 + REG_AW + DATA_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic [REG_AW-1:0]      in_rj;
    logic [REG_AW-1:0]      in_rkd;
    logic [DATA_W-1:0]      in_rj_value;
    logic [DATA_W-1:0]      in_rkd_value;
    logic [CNT_W-1:0]       in_mc_cycles;
    logic [NUM_FWD*SW-1:0]  fwd_bus;
    logic                   br_taken;
    logic                   out_valid;
    logic                   out_ready;
    logic [PAYLOAD_W-1:0]   out_payload;
    logic [DATA_W-1:0]      src1;
    logic [DATA_W-1:0]      src2;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    exe_issue_pipe #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD),
        .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_rj(in_rj), .in_rkd(in_rkd),
        .in_rj_value(in_rj_value), .in_rkd_value(in_rkd_value),
        .in_mc_cycles(in_mc_cycles), .fwd_bus(fwd_bus), .br_taken(br_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .src1(src1), .src2(src2), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [PAYLOAD_W-1:0] mkpl(input logic [31:0] s);
        return {s[12:0], {7{s}}};
    endfunction

    function automatic logic [SW-1:0] fsrc(input logic we, input logic pend,
                                           input logic [REG_AW-1:0] d,
                                           input logic [DATA_W-1:0] v);
        return {we, pend, d, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] tag, input logic [REG_AW-1:0] rj,
                         input logic [REG_AW-1:0] rkd, input logic [DATA_W-1:0] v1,
                         input logic [DATA_W-1:0] v2, input logic [CNT_W-1:0] mc);
        in_valid     = 1'b1;
        in_payload   = mkpl(tag);
        in_rj        = rj;
        in_rkd       = rkd;
        in_rj_value  = v1;
        in_rkd_value = v2;
        in_mc_cycles = mc;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; br_taken = 1'b0; out_ready = 1'b0;
        fwd_bus = '0;
        offer(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        step(); step();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_forward_priority();
        out_ready = 1'b0;
        offer(32'h1001, 5'd5, 5'd0, 32'h1111, 32'h2222, 6'd0);
        step();
        in_valid = 1'b0;
        fwd_bus = {fsrc(1'b1, 1'b0, 5'd5, 32'hBBBB), fsrc(1'b1, 1'b0, 5'd5, 32'hAAAA)};
        #1;
        checks++; if (src1 !== 32'hAAAA) begin errors++; $display("FAIL fwd_priority got=%h exp=0000aaaa", src1); end
        checks++; if (src2 !== 32'h2222) begin errors++; $display("FAIL fwd_nomatch got=%h exp=00002222", src2); end
        fwd_bus = {fsrc(1'b1, 1'b0, 5'd5, 32'hBBBB), fsrc(1'b1, 1'b0, 5'd6, 32'hAAAA)};
        #1;
        checks++; if (src1 !== 32'hBBBB) begin errors++; $display("FAIL fwd_src1_only got=%h exp=0000bbbb", src1); end
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_payload !== mkpl(32'h1001)) begin errors++; $display("FAIL fwd_payload got=%h", out_payload[31:0]); end
        step();
        // rj = 0 never matches even with a dest=0 forward
        out_ready = 1'b0;
        fwd_bus = {fsrc(1'b0, 1'b0, 5'd0, 32'h0), fsrc(1'b1, 1'b0, 5'd0, 32'hFFFF)};
        offer(32'h1002, 5'd0, 5'd0, 32'h3333, 32'h4444, 6'd0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drained got=%b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (src1 !== 32'h3333) begin errors++; $display("FAIL fwd_r0 got=%h exp=00003333", src1); end
        out_ready = 1'b1;
        step();
        fwd_bus = '0;
    endtask

    task automatic test_load_use();
        out_ready = 1'b0;
        offer(32'h2001, 5'd0, 5'd7, 32'h0, 32'h5555, 6'd0);
        step();
        in_valid = 1'b0;
        fwd_bus = {fsrc(1'b0, 1'b0, 5'd0, 32'h0), fsrc(1'b1, 1'b1, 5'd7, 32'hEEEE)};
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lu_busy cyc=%0d got=%b exp=1", c, busy); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
            step();
        end
        fwd_bus = {fsrc(1'b0, 1'b0, 5'd0, 32'h0), fsrc(1'b1, 1'b0, 5'd7, 32'h1234)};
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_release got=%b exp=1", out_valid); end
        checks++; if (src2 !== 32'h1234) begin errors++; $display("FAIL lu_src2 got=%h exp=00001234", src2); end
        step();
        fwd_bus = '0;
        #1;
        checks++; if (src2 !== 32'h1234) begin errors++; $display("FAIL lu_src2_kept got=%h exp=00001234", src2); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_hold got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_multicycle();
        out_ready = 1'b1;
        offer(32'h3001, 5'd0, 5'd0, 32'h0, 32'h0, 6'd3);
        step();
        offer(32'h3002, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mc_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mc_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
            step();
        end
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mc_done got=%b exp=1", out_valid); end
        checks++; if (out_payload !== mkpl(32'h3001)) begin errors++; $display("FAIL mc_payload got=%h", out_payload[31:0]); end
        step();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) offer(32'h3003 + k, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
            else in_valid = 1'b0;
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_payload !== mkpl(32'h3002 + k)) begin errors++; $display("FAIL b2b_payload k=%0d got=%h", k, out_payload[31:0]); end
            step();
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_mc_max();
        int n;
        out_ready = 1'b1;
        offer(32'h3100, 5'd0, 5'd0, 32'h0, 32'h0, 6'h3F);
        step();
        in_valid = 1'b0;
        n = 0;
        #1;
        while (out_valid !== 1'b1 && n < 200) begin
            step();
            n++;
            #1;
        end
        checks++; if (n !== 63) begin errors++; $display("FAIL mc_max_latency got=%0d exp=63", n); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(32'h4001, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        step();
        offer(32'h4002, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (out_payload !== mkpl(32'h4001) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b", c, out_payload[31:0], out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (out_payload !== mkpl(32'h4002) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next got=%h/%b", out_payload[31:0], out_valid); end
        step();
    endtask

    task automatic test_branch_squash();
        out_ready = 1'b0;
        br_taken  = 1'b1;
        offer(32'h5001, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        step();
        in_valid = 1'b0;
        step();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL br_ignored_no_fire got=%b exp=1", out_valid); end
        offer(32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL br_consume got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; br_taken = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL br_squash_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL br_squash_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        offer(32'h6001, 5'd0, 5'd0, 32'h0, 32'h0, 6'd5);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        flush = 1'b1;
        offer(32'h6002, 5'd0, 5'd0, 32'h0, 32'h0, 6'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        step(); step();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_hazard();
        out_ready = 1'b1;
        offer(32'h7001, 5'd0, 5'd7, 32'h0, 32'h0, 6'd0);
        step();
        in_valid = 1'b0;
        fwd_bus = {fsrc(1'b1, 1'b1, 5'd7, 32'h0), fsrc(1'b0, 1'b0, 5'd0, 32'h0)};
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_hz_busy got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_hz_in_ready got=%b exp=0", in_ready); end
        step();
        reset = 1'b0; fwd_bus = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hz_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hz_busy_clr got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_hz_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_forward_priority();
        test_load_use();
        test_multicycle();
        test_mc_max();
        test_backpressure();
        test_branch_squash();
        test_flush();
        test_reset_mid_hazard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_issue_pipe.md
Name: exe_issue_pipe

Overview:
- Parametrised execute-stage pipeline register and operand-forwarding unit; successor to the fixed two-source, stall-vector execute front end.
- Replaces the global stall vector with a valid/ready handshake.
- Supports NUM_FWD forwarding sources with load-use (pending) detection, a per-instruction multicycle hold counter, and squash of the wrong-path beat accepted while a taken branch leaves.
- Sits between decode and the ALU/BRU/LSU/mul-div datapath.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest, highest priority
PAYLOAD_W, 237, opaque decoded-instruction bus carried through unchanged
CNT_W, 6, width of multicycle hold count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  kill held entry; block accept this cycle
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage accepts this cycle
in_payload  in  PAYLOAD_W  decoded instruction bus
in_rj  in  REG_AW  source-1 register address
in_rkd  in  REG_AW  source-2 register address
in_rj_value  in  DATA_W  regfile value for rj
in_rkd_value  in  DATA_W  regfile value for rkd
in_mc_cycles  in  CNT_W  extra hold cycles (0 = single-cycle op)
fwd_bus  in  NUM_FWD*(2+REG_AW+DATA_W)  per source {we, pending, dest, data}; source i at slice i
br_taken  in  1  held entry resolves taken (from BRU, combinational on src1/src2)
out_valid  out  1  held entry complete
out_ready  in  1  memory stage accepts
out_payload  out  PAYLOAD_W  registered payload
src1  out  DATA_W  forwarded operand 1
src2  out  DATA_W  forwarded operand 2
busy  out  1  entry held but incomplete (stall request)

Behaviour:
- State: valid_r, payload_r, rj_r, rkd_r, v1_r, v2_r, cnt_r. All reset to 0.
- During reset, in_ready = 0 and out_valid = 0. After reset: in_ready = 1, out_valid = 0, busy = 0.
- Forwarding, per operand, combinational:
  - Address 0 never matches.
  - Scan sources 0..NUM_FWD-1. The first source with we & dest == addr wins.
  - Winner not pending: src = winner data. Winner pending: hazard, src = don't-care. No match: src = v*_r.
- hazard = valid_r & (pending match on rj_r or rkd_r).
- Operand refresh:
  - Each cycle valid_r is held and the entry does not fire, v1_r/v2_r are loaded with non-pending forwarded values.
  - Values forwarded from draining stages are therefore not lost across stalls.
- Multicycle hold:
  - On accept, cnt_r <= in_mc_cycles.
  - While valid_r & !hazard & cnt_r != 0, cnt_r decrements by 1 per cycle.
  - cnt_r does not decrement while hazard is asserted.
- Completion and output:
  - complete = valid_r & !hazard & cnt_r == 0.
  - out_valid = complete & !flush.
  - fire = out_valid & out_ready.
  - busy = valid_r & !complete.
- in_ready = !reset & !flush & (!valid_r | fire); combinational through out_ready.
- Accept = in_valid & in_ready. Captures payload, rj, rkd, regfile values and count. valid_r <= 1.
- Branch squash:
  - If fire & br_taken in the same cycle as accept, the accepted beat is wrong-path and is consumed but dropped (valid_r <= 0).
  - br_taken is ignored when not firing.
- Fire without accept: valid_r <= 0.
- Flush:
  - Highest priority below reset. Next cycle valid_r = 0, cnt_r = 0.
  - Applies even mid-multicycle or mid-hazard.
- out_valid holds stable with payload until fire. Payload must not change while out_valid & !out_ready.
- Throughput: 1 instruction/cycle when in_mc_cycles = 0 and no hazard. An op with in_mc_cycles = N occupies the stage N+1 cycles.
- in_mc_cycles of all-ones is legal (2^CNT_W - 1 extra cycles).

Test Plan:
- Forward priority: rj=5; src0 {we=1,pend=0,dest=5,data=0xAAAA}; src1 {we=1,dest=5,data=0xBBBB} -> src1 output = 0xAAAA. rj=0 with a dest=0 match -> regfile value.
- Load-use: src0 pending on rkd=7 for 2 cycles, then data 0x1234 -> busy = 1 and out_valid = 0 for 2 cycles; next cycle out_valid = 1, src2 = 0x1234. Forwarding then drops while out_ready = 0 -> src2 stays 0x1234.
- Multicycle: in_mc_cycles = 3, out_ready = 1 -> out_valid is first high 3 cycles after the accept edge (4 cycles occupied), in_ready = 0 meanwhile. Back-to-back single-cycle ops -> 1 per cycle.
- Backpressure: out_ready = 0 for 4 cycles -> out_payload stable, in_ready = 0. out_ready = 1 -> fire and accept next beat in the same cycle.
- Branch squash: held branch fires with br_taken = 1 while in_valid = 1 (payload 0xDEAD…) -> that beat is consumed, next cycle valid_r = 0, out_valid = 0.
- Flush/reset mid-op: flush at count 2 of 5 -> next cycle out_valid = 0, busy = 0, in_ready = 1. reset asserted mid-hazard -> same, and in_ready = 0 while reset is high.
